// File: rtl/vrom_pixel_reader_if.sv
// Bus bundle between the raster reader, the video ROM read port and the VGA pins.
//   Address    : ROM read address, driven by the reader
//   DataIn     : ROM read data, driven by the ROM one CLK after Address changes
//   RGB        : pixel colour to the connector (R[11:8] G[7:4] B[3:0])
//   HSync      : horizontal sync, active low
//   VSync      : vertical sync, active low
//   Active     : high while RGB carries a visible pixel
//   FrameStart : one-CLK pulse when the raster wraps to (0,0)
// master = the reader, slave = the ROM / pin side.
interface vrom_pixel_reader_if #(
  parameter int unsigned ROM_WIDTH     = 12,
  parameter int unsigned ROM_ADDR_BITS = 20
);
  logic [ROM_ADDR_BITS-1:0] Address;
  logic [ROM_WIDTH-1:0]     DataIn;
  logic [ROM_WIDTH-1:0]     RGB;
  logic                     HSync;
  logic                     VSync;
  logic                     Active;
  logic                     FrameStart;

  modport master (
    output Address,
    output RGB,
    output HSync,
    output VSync,
    output Active,
    output FrameStart,
    input  DataIn
  );

  modport slave (
    input  Address,
    input  RGB,
    input  HSync,
    input  VSync,
    input  Active,
    input  FrameStart,
    output DataIn
  );
endinterface

// File: rtl/vrom_pixel_reader.sv
// Raster-scan reader for a video ROM with a 1-CLK registered read port.
// Generates VGA timing from pixel-rate ticks, walks the ROM address in raster order
// and emits RGB plus sync signals delayed by exactly one pixel tick so that they line
// up with the ROM data that answers the previous address.
// Ports:
//   CLK       : system clock, all state on its rising edge
//   RESET     : asynchronous, active-high reset
//   PixelTick : pixel-rate enable, one CLK wide, pulses at least 2 CLK apart
//   bus       : master side of vrom_pixel_reader_if (Address/DataIn, RGB, syncs,
//               Active, FrameStart)
module vrom_pixel_reader #(
  parameter int unsigned ROM_WIDTH     = 12,
  parameter int unsigned ROM_ADDR_BITS = 20,
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33
) (
  input logic                CLK,
  input logic                RESET,
  input logic                PixelTick,
  vrom_pixel_reader_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Sized copies of the timing constants keep every compare width-matched.
  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS      = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_FIRST   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_LAST    = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HCW-1:0] H_ONE      = HCW'(1);
  localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS      = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_FIRST   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_LAST    = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VCW-1:0] V_ONE      = VCW'(1);
  localparam logic [ROM_ADDR_BITS-1:0] ADDR_ONE = ROM_ADDR_BITS'(1);

  logic [HCW-1:0]           hc_q;
  logic [VCW-1:0]           vc_q;
  logic [ROM_ADDR_BITS-1:0] addr_q;
  logic [ROM_WIDTH-1:0]     rgb_q;
  logic                     hsync_q;
  logic                     vsync_q;
  logic                     active_q;
  logic                     frame_start_q;

  logic vis;
  logic h_wrap;
  logic v_wrap;
  logic in_hsync;
  logic in_vsync;

  // Everything below is decoded from the pre-increment counter values.
  always_comb begin
    vis      = (hc_q < H_VIS) && (vc_q < V_VIS);
    h_wrap   = (hc_q == H_LAST);
    v_wrap   = (vc_q == V_LAST);
    in_hsync = (hc_q >= HS_FIRST) && (hc_q <= HS_LAST);
    in_vsync = (vc_q >= VS_FIRST) && (vc_q <= VS_LAST);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hc_q          <= '0;
      vc_q          <= '0;
      addr_q        <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (PixelTick) begin
        // Raster counters.
        if (h_wrap) begin
          hc_q <= '0;
          vc_q <= v_wrap ? '0 : vc_q + V_ONE;
        end else begin
          hc_q <= hc_q + H_ONE;
        end

        // Address tracks the raster index incrementally: it advances once per visible
        // pixel, parks at V_ACTIVE*H_ACTIVE through the vertical blank and rewinds
        // only on the frame wrap.
        if (h_wrap && v_wrap) begin
          addr_q        <= '0;
          frame_start_q <= 1'b1;
        end else if (vis) begin
          addr_q <= addr_q + ADDR_ONE;
        end

        // DataIn answers the address that described the position being retired here,
        // so the colour and the syncs all refer to the same pixel.
        rgb_q    <= vis ? bus.DataIn : '0;
        active_q <= vis;
        hsync_q  <= ~in_hsync;
        vsync_q  <= ~in_vsync;
      end
    end
  end

  assign bus.Address    = addr_q;
  assign bus.RGB        = rgb_q;
  assign bus.HSync      = hsync_q;
  assign bus.VSync      = vsync_q;
  assign bus.Active     = active_q;
  assign bus.FrameStart = frame_start_q;

endmodule

// File: doc/vrom_pixel_reader.md
Name: vrom_pixel_reader

Overview:
- Raster-scan reader for the 12-bit video ROM (1-clock registered read, 20-bit address).
- Generates VGA 640x480 timing and drives the ROM address in raster order.
- Consumes the ROM data and outputs time-aligned RGB 4:4:4 pixels plus sync signals to the VGA connector.
- Sits between the video ROM and the top-level VGA pins; it is the initiator for the ROM's read port.

Parameters:
ROM_WIDTH, 12, pixel word width (R[11:8], G[7:4], B[3:0])
ROM_ADDR_BITS, 20, ROM address width
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
CLK  input  1  system clock; all state updates on its rising edge
RESET  input  1  asynchronous, active-high reset
PixelTick  input  1  pixel-rate enable; one CLK-wide pulse per pixel; consecutive pulses at least 2 CLK apart
DataIn  input  ROM_WIDTH  ROM read data; valid 1 CLK after Address changes
Address  output  ROM_ADDR_BITS  registered ROM read address
RGB  output  ROM_WIDTH  registered pixel colour; 0 outside the active area
HSync  output  1  horizontal sync, active low, registered
VSync  output  1  vertical sync, active low, registered
Active  output  1  high while RGB carries a visible pixel, registered
FrameStart  output  1  one-CLK pulse when the counters wrap to (0,0)

Behaviour:
Reset
- RESET high clears the internal counters HC and VC to 0.
- Outputs on reset: Address=0, RGB=0, HSync=1, VSync=1, Active=0, FrameStart=0.
- Reset asserted mid-frame aborts the frame immediately.
- After release, scanning restarts at (0,0) with Address=0 on the next PixelTick.

Counters (update only on CLK edges with PixelTick=1)
- HC counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- VC counts 0..V_TOTAL-1, where V_TOTAL = 525; VC increments when HC wraps.
- Both counters wrap to 0 together after (799,524).
- vis = (HC<H_ACTIVE) && (VC<V_ACTIVE), evaluated on the pre-increment values.

Address generation (incremental; no multiplier)
- On a tick where vis=1: Address <= Address+1.
- On a tick that wraps both counters to (0,0): Address <= 0, and FrameStart pulses for that one CLK.
- Otherwise Address holds; during blanking it holds at 307200.
- Wrap modulo 2^ROM_ADDR_BITS is permitted; it cannot occur with the defaults.
- Address always equals the raster index of the position currently held in (HC,VC) when that position is visible.

Output stage (one-tick pipeline; updates only on PixelTick)
- On each tick, outputs describe the pre-increment position (HC,VC):
  - RGB <= vis ? DataIn : 0
  - Active <= vis
  - HSync <= ~(HC in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) = ~(HC in [656,751])
  - VSync <= ~(VC in [490,491])
- RGB, HSync, VSync and Active therefore lag the counters by exactly one pixel tick and stay mutually aligned.
- DataIn is sampled at least 1 CLK after Address changed; this is guaranteed by the ≥2-CLK tick spacing.
- Between ticks, all outputs hold.
- If PixelTick stays low, all state freezes.
- Tick spacing below 2 CLK is unsupported; the design must not hang, but RGB content is then undefined.

Test Plan:
- Reset check: assert RESET mid-line at HC=300 -> Address=0, RGB=0, HSync=VSync=1, Active=0 immediately; after release, the first tick gives Address=1 and the second RGB equals ROM[0].
- Ramp ROM (ROM[i]=i[11:0]), PixelTick every 4 CLK -> on line 0, RGB sequence 0x000, 0x001, ... 0x27F with Active=1 for 640 ticks; then RGB=0 and Active=0 for 160 ticks.
- Horizontal timing -> HSync low for exactly 96 ticks, first going low on the tick after HC=656; period 800 ticks.
- Vertical timing and frame wrap -> VSync low for 2 lines (lines 490-491), frame = 420000 ticks; FrameStart pulses once per frame; Address=307200 during vertical blank and 0 after the wrap; the second frame's first pixel is ROM[0].
- Line-boundary addressing -> the first pixel of line 1 is ROM[640] and the last pixel of line 479 is ROM[307199].
- Stall: hold PixelTick low for 50 CLK mid-line -> every output and Address unchanged; resuming continues the sequence with no skipped or duplicated pixel.
